// File: rtl/text_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : text_ram_arbiter
// Purpose  : Single-port text RAM owner: power-up line clear, then arbitrates
//            renderer (priority, burst-limited), controller and host access.
// Revision : 1.0
// ============================================================================
module text_ram_arbiter #(
    parameter int          LINES            = 24,
    parameter int          LINE_W           = 2560,
    parameter int          RD_LATENCY       = 2,
    parameter logic [31:0] CLEAR_DATA       = 32'h0007fc20,
    parameter int          RENDER_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [7:0]        addr0,
    output logic              ack0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              req2,
    input  logic              we1,
    input  logic              we2,
    input  logic [7:0]        addr1,
    input  logic [7:0]        addr2,
    input  logic [LINE_W-1:0] wdata1,
    input  logic [LINE_W-1:0] wdata2,
    output logic              ack1,
    output logic              ack2,
    output logic              rvalid1,
    output logic              rvalid2,
    output logic [LINE_W-1:0] rdata,
    output logic [7:0]        ram_addr,
    output logic              ram_wren,
    output logic [LINE_W-1:0] ram_wdata,
    input  logic [LINE_W-1:0] ram_rdata,
    output logic              init_done
);

    localparam logic [LINE_W-1:0] c_blank     = {(LINE_W/32){CLEAR_DATA}};
    localparam logic [7:0]        c_lines     = 8'(LINES);
    localparam int                c_bw        = $clog2(RENDER_BURST_MAX + 1);
    localparam logic [c_bw-1:0]   c_burst_max = c_bw'(RENDER_BURST_MAX);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t          r_state;
    logic [7:0]      r_row;
    logic [c_bw-1:0] r_burst;
    logic            r_rr_p2;      // 1: port 2 is favoured next between ports 1/2
    // Read tag layout: {valid, port[1:0], out_of_range}
    logic [3:0]      r_rd_tag;
    logic [3:0]      r_pipe [RD_LATENCY];

    logic w_block, w_g0, w_g1, w_g2;
    logic [3:0] w_last;

    always_comb begin
        w_block = (r_burst >= c_burst_max) && (req1 || req2);
        w_g0    = req0 && !w_block;
        w_g1    = 1'b0;
        w_g2    = 1'b0;
        if (!w_g0) begin
            if (req1 && (!r_rr_p2 || !req2))
                w_g1 = 1'b1;
            else if (req2)
                w_g2 = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_row     <= '0;
            r_burst   <= '0;
            r_rr_p2   <= 1'b0;
            r_rd_tag  <= '0;
            init_done <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            ack2      <= 1'b0;
            ram_addr  <= '0;
            ram_wren  <= 1'b0;
            ram_wdata <= '0;
            for (int i = 0; i < RD_LATENCY; i++)
                r_pipe[i] <= '0;
        end else begin
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            ack2     <= 1'b0;
            ram_wren <= 1'b0;
            r_rd_tag <= '0;
            r_pipe[0] <= r_rd_tag;
            for (int i = 1; i < RD_LATENCY; i++)
                r_pipe[i] <= r_pipe[i-1];

            case (r_state)
                ST_CLEAR: begin
                    if (r_row == c_lines) begin
                        r_state   <= ST_SERVE;
                        init_done <= 1'b1;
                    end else begin
                        ram_wren  <= 1'b1;
                        ram_addr  <= r_row;
                        ram_wdata <= c_blank;
                        r_row     <= r_row + 8'd1;
                    end
                end
                ST_SERVE: begin
                    if (w_g0) begin
                        ack0     <= 1'b1;
                        ram_addr <= addr0;
                        r_rd_tag <= {1'b1, 2'd0, !(addr0 < c_lines)};
                        if (r_burst < c_burst_max)
                            r_burst <= r_burst + 1'b1;
                    end else begin
                        r_burst <= '0;
                    end
                    if (w_g1) begin
                        ack1      <= 1'b1;
                        ram_addr  <= addr1;
                        ram_wdata <= wdata1;
                        ram_wren  <= we1 && (addr1 < c_lines);
                        r_rd_tag  <= {!we1, 2'd1, !(addr1 < c_lines)};
                        r_rr_p2   <= 1'b1;
                    end
                    if (w_g2) begin
                        ack2      <= 1'b1;
                        ram_addr  <= addr2;
                        ram_wdata <= wdata2;
                        ram_wren  <= we2 && (addr2 < c_lines);
                        r_rd_tag  <= {!we2, 2'd2, !(addr2 < c_lines)};
                        r_rr_p2   <= 1'b0;
                    end
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    assign w_last  = r_pipe[RD_LATENCY-1];
    assign rvalid0 = w_last[3] && (w_last[2:1] == 2'd0);
    assign rvalid1 = w_last[3] && (w_last[2:1] == 2'd1);
    assign rvalid2 = w_last[3] && (w_last[2:1] == 2'd2);
    assign rdata   = w_last[0] ? c_blank : ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_text_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_ram_arbiter
// Purpose  : Directed checks of clear sweep, read latency, burst limit,
//            round-robin, out-of-range handling and reset mid-read.
// Revision : 1.0
// ============================================================================
module tb_text_ram_arbiter;

    localparam int LW = 2560;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, req2 = 1'b0;
    logic          we1 = 1'b0, we2 = 1'b0;
    logic [7:0]    addr0 = '0, addr1 = '0, addr2 = '0;
    logic [LW-1:0] wdata1 = '0, wdata2 = '0;
    logic          ack0, ack1, ack2, rvalid0, rvalid1, rvalid2;
    logic [LW-1:0] rdata, ram_wdata, ram_rdata;
    logic [7:0]    ram_addr;
    logic          ram_wren, init_done;

    logic [LW-1:0] mem [256];
    logic [7:0]    r_a1;
    logic [LW-1:0] blank, pa, pb, pc;

    int nvec = 0;
    int nerr = 0;

    text_ram_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .ack0(ack0), .rvalid0(rvalid0),
        .req1(req1), .req2(req2), .we1(we1), .we2(we2),
        .addr1(addr1), .addr2(addr2), .wdata1(wdata1), .wdata2(wdata2),
        .ack1(ack1), .ack2(ack2), .rvalid1(rvalid1), .rvalid2(rvalid2),
        .rdata(rdata), .ram_addr(ram_addr), .ram_wren(ram_wren),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Two-cycle RAM: address registered, then data registered
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        r_a1      <= ram_addr;
        ram_rdata <= mem[r_a1];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rv(input int p);
        return (p == 0) ? rvalid0 : (p == 1) ? rvalid1 : rvalid2;
    endfunction

    task automatic access(input int p, input logic w, input logic [7:0] a, input logic [LW-1:0] d);
        logic seen;
        case (p)
            0: begin req0 = 1'b1; addr0 = a; end
            1: begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
            default: begin req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d; end
        endcase
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = (p == 0) ? ack0 : (p == 1) ? ack1 : ack2;
        end
        chk($sformatf("ack%0d_seen", p), 64'(seen), 64'd1);
        req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
    endtask

    task automatic read_check(input string tag, input int p, input logic [7:0] a, input logic [LW-1:0] exp);
        access(p, 1'b0, a, '0);
        chk({tag, "_addr"}, 64'(ram_addr), 64'(a));
        chk({tag, "_wren"}, 64'(ram_wren), 64'd0);
        @(negedge clk);
        chk({tag, "_early"}, 64'(rv(p)), 64'd0);
        @(negedge clk);
        chk({tag, "_rvalid"}, {61'd0, rvalid2, rvalid1, rvalid0}, 64'd1 << p);
        chk({tag, "_eq"}, 64'(rdata == exp), 64'd1);
        chk({tag, "_lo"}, rdata[63:0], exp[63:0]);
    endtask

    logic [1:0] burst_exp [10];
    logic [1:0] rr_exp [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        blank = {80{32'h0007fc20}};
        pa    = {80{32'hA5A50003}};
        pb    = {80{32'h1234000A}};
        pc    = {80{32'hBEEF000B}};
        for (int i = 0; i < 256; i++) mem[i] = {80{32'hDEADBEEF}};
        burst_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                      2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        rr_exp    = '{2'b01, 2'b10, 2'b01, 2'b10};

        // All requests high through reset and the clear sweep
        req0 = 1'b1; req1 = 1'b1; req2 = 1'b1; we1 = 1'b1; we2 = 1'b1;
        addr0 = 8'd1; addr1 = 8'd2; addr2 = 8'd3;
        repeat (2) @(negedge clk);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_wren", 64'(ram_wren), 64'd0);
        chk("rst_addr", 64'(ram_addr), 64'd0);
        chk("rst_acks", {61'd0, ack2, ack1, ack0}, 64'd0);
        chk("rst_rvalid", {61'd0, rvalid2, rvalid1, rvalid0}, 64'd0);
        rst = 1'b0;

        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            chk("clr_wren", 64'(ram_wren), 64'd1);
            chk("clr_addr", 64'(ram_addr), 64'(n));
            chk("clr_data", ram_wdata[63:0], blank[63:0]);
            chk("clr_noack", {61'd0, ack2, ack1, ack0}, 64'd0);
            chk("clr_not_done", 64'(init_done), 64'd0);
        end
        @(negedge clk);
        chk("init_done", 64'(init_done), 64'd1);
        chk("post_clr_wren", 64'(ram_wren), 64'd0);
        chk("post_clr_noack", {61'd0, ack2, ack1, ack0}, 64'd0);
        req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;

        read_check("rd5_blank", 1, 8'd5, blank);
        access(1, 1'b1, 8'd3, pa);
        chk("wr3_wren", 64'(ram_wren), 64'd1);
        read_check("rd3", 1, 8'd3, pa);

        // Renderer burst limit with port 1 pending continuously
        req0 = 1'b1; addr0 = 8'd7; req1 = 1'b1; we1 = 1'b0; addr1 = 8'd4;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("burst_%0d", i), {62'd0, ack1, ack0}, 64'(burst_exp[i]));
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);

        access(1, 1'b1, 8'd30, pb);
        chk("oor_wr_wren", 64'(ram_wren), 64'd0);
        read_check("oor_rd", 2, 8'd200, blank);

        // Round-robin: port 2 was last, so port 1 goes first
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'd10; wdata1 = pb;
        req2 = 1'b1; we2 = 1'b1; addr2 = 8'd11; wdata2 = pc;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rr_ack_%0d", i), {62'd0, ack2, ack1}, 64'(rr_exp[i]));
            chk($sformatf("rr_wdata_%0d", i), ram_wdata[63:0], rr_exp[i][0] ? pb[63:0] : pc[63:0]);
            chk($sformatf("rr_addr_%0d", i), 64'(ram_addr), rr_exp[i][0] ? 64'd10 : 64'd11);
            chk($sformatf("rr_wren_%0d", i), 64'(ram_wren), 64'd1);
        end
        req1 = 1'b0; req2 = 1'b0;
        @(negedge clk);
        read_check("raw_11", 1, 8'd11, pc);
        read_check("raw_10", 2, 8'd10, pb);

        // Reset one cycle after the ack of an in-flight read
        access(2, 1'b0, 8'd3, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_wren", 64'(ram_wren), 64'd0);
        chk("mid_rst_init", 64'(init_done), 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mid_rst_rvalid2", 64'(rvalid2), 64'd0);
        end
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("reclr_rvalid2", 64'(rvalid2), 64'd0);
            chk("reclr_addr", 64'(ram_addr), 64'(n));
            chk("reclr_wren", 64'(ram_wren), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/text_ram_arbiter.md
Name: text_ram_arbiter

Overview:
- Owns the single port of the text RAM, one line per address.
- Shares it between three requesters:
  - 0: VGA renderer line fetch (read-only, priority).
  - 1: text controller (read/write).
  - 2: host/debug port (read/write).
- After reset it clears every line before accepting any request, so no line ever shows garbage at power-up.

Parameters:
- LINES, 24, number of text lines (RAM depth used).
- LINE_W, 2560, line width in bits (80 columns x 32 bits).
- RD_LATENCY, 2, cycles from ram_addr presented to ram_rdata valid (fixed, ≥1).
- CLEAR_DATA, 32'h0007fc20, per-character blank pattern, replicated LINE_W/32 times.
- RENDER_BURST_MAX, 4, max consecutive renderer grants while another requester waits.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req0  in  1  renderer read request
- addr0  in  8  renderer line address
- ack0  out  1  renderer grant pulse
- rvalid0  out  1  renderer read data valid
- req1, req2  in  1  controller / host request
- we1, we2  in  1  1 = write, 0 = read
- addr1, addr2  in  8  line address
- wdata1, wdata2  in  LINE_W  write data
- ack1, ack2  out  1  grant pulse
- rvalid1, rvalid2  out  1  read data valid
- rdata  out  LINE_W  shared read data, qualified by rvalidN
- ram_addr  out  8  RAM address
- ram_wren  out  1  RAM write enable
- ram_wdata  out  LINE_W  RAM write data
- ram_rdata  in  LINE_W  RAM read data
- init_done  out  1  high once the initial clear completes

Behaviour:
- Reset: all ack/rvalid, ram_wren, ram_addr, ram_wdata and init_done go to 0. The read-tag pipeline is flushed, so no rvalid may fire for reads issued before reset. The FSM enters CLEAR.
- CLEAR state:
  - Each cycle: ram_wren=1, ram_addr=row, ram_wdata=CLEAR_DATA replicated; row increments from 0 to LINES-1.
  - The cycle after the row LINES-1 write, go to SERVE and set init_done=1, which holds until reset.
  - Requests are ignored (no ack) during CLEAR.
- SERVE state, one grant per cycle, decided from req inputs sampled at edge k:
  - Priority: req0 wins unless RENDER_BURST_MAX consecutive renderer grants have occurred and req1 or req2 is pending. In that case one non-renderer grant is issued, then the burst counter resets.
  - The burst counter also resets on any cycle without a renderer grant.
  - Between req1 and req2: round-robin. The pointer flips to the other port after each port-1/2 grant. Reset value favours port 1.
  - At edge k+1: ackN=1 for exactly one cycle. ram_addr/ram_wren/ram_wdata carry the granted access (registered).
  - With no grant, ram_wren=0 and ram_addr/ram_wdata hold their last values.
- Requester rules:
  - Hold reqN, weN, addrN, wdataN stable until ackN is seen.
  - Deassert the cycle after ack, or keep req high to request back-to-back.
  - The arbiter may re-grant the same port the next cycle if it still wins.
- Reads:
  - A tag (port id, out-of-range flag) travels a RD_LATENCY-deep shift register.
  - rvalidN is high in the cycle ram_rdata is valid, i.e. RD_LATENCY cycles after the ack cycle.
  - rdata = ram_rdata combinationally, except out-of-range reads, which return CLEAR_DATA replicated.
  - Pipelined reads return in issue order, one per cycle.
- Address ≥ LINES: the access is acked normally. Writes are dropped (ram_wren=0); reads return blank data as above.
- Port 0 ignores we (always read).
- Simultaneous req0/req1/req2 with burst not exhausted: port 0 acked; 1 and 2 wait with no ack.
- A read-after-write to the same line from a different port observes the new data. The RAM is write-first at the next access, and the arbiter adds no forwarding.
- Reset mid-operation (CLEAR or SERVE): immediate return to reset values, and the clear restarts from row 0.

Test Plan:
- CLEAR sweep: release reset with LINES=24, all req high → 24 consecutive writes of rows 0..23 with CLEAR_DATA. No ack during the sweep; init_done rises at cycle 25. A read of row 5 then returns the blank pattern.
- Read latency: req1=1, we1=0, addr1=3 → ack1 one cycle later, ram_addr=3, rvalid1 exactly 2 cycles after ack1 with row 3 data. No rvalid on ports 0 and 2.
- Renderer burst limit: req0 and req1 held high continuously → grant pattern 0,0,0,0,1,0,0,0,0,1… with each ack1 a single pulse.
- Round-robin fairness: req1 and req2 held high, req0 low, both writing → acks alternate 1,2,1,2. ram_wdata matches the granted port each cycle.
- Out-of-range: write addr1=30 → ack1 asserted, ram_wren stays 0. Read addr2=200 → rvalid2 with rdata = blank pattern.
- Reset mid-read: issue a read on port 2, then assert rst one cycle after ack2 → rvalid2 never asserted. A CLEAR sweep restarts from row 0.
